blue_exec_unit: RTL and testbench

//  Registered execute stage for the Blue datapath. Replaces the combinational result selector.

---
 rtl/blue_exec_unit.sv | 147 ++++++++++++++
 tb/tb_blue_exec_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/blue_exec_unit.sv
// Blue datapath execute stage: registered ALU with iterative logical right shift.
// Valid/ready on both sides; results and flags held until downstream accepts.
module blue_exec_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   ra,
  input  logic [WIDTH-1:0]   rb,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_n
);

  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;
  localparam logic [2:0] OP_XOR  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_EXCH = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_valid;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_z;
  logic               r_c;
  logic               r_n;
  logic [WIDTH-1:0]   r_sh;
  logic [WIDTH-1:0]   r_shb;
  logic [SHAMT_W-1:0] r_cnt;

  logic               w_accept;
  logic               w_long;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_dif;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_c;
  logic [WIDTH-1:0]   w_shn;

  assign in_ready  = (r_state == S_IDLE) |
                     ((r_state == S_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_long    = (op == OP_SHR) & (shamt != '0);
  assign w_sum     = {1'b0, ra} + {1'b0, rb};
  assign w_dif     = {1'b0, ra} - {1'b0, rb};
  assign w_shn     = r_sh >> 1;

  assign out_valid = r_valid;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_n    = r_n;

  // Single-cycle results; SHR here only covers shamt==0
  always_comb begin
    w_a = '0;
    w_b = rb;
    w_c = 1'b0;
    unique case (op)
      OP_ADD:  begin w_a = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH]; end
      OP_SUB:  begin w_a = w_dif[WIDTH-1:0]; w_c = w_dif[WIDTH]; end
      OP_OR:   w_a = ra | rb;
      OP_AND:  w_a = ra & rb;
      OP_XOR:  w_a = ra ^ rb;
      OP_SHR:  w_a = ra;
      OP_MOV:  begin w_a = ra; w_b = ra; end
      OP_EXCH: begin w_a = rb; w_b = ra; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_n     <= 1'b0;
      r_sh    <= '0;
      r_shb   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept && w_long) begin
            r_state <= S_SHIFT;
            r_valid <= 1'b0;
            r_sh    <= ra;
            r_shb   <= rb;
            r_cnt   <= shamt;
          end else if (w_accept) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_a     <= w_a;
            r_b     <= w_b;
            r_z     <= (w_a == '0);
            r_c     <= w_c;
            r_n     <= w_a[WIDTH-1];
          end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_sh  <= w_shn;
          r_cnt <= r_cnt - 1'b1;
          // Final shift: its shifted-out bit becomes the carry
          if (r_cnt == SHAMT_W'(1)) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_a     <= w_shn;
            r_b     <= r_shb;
            r_z     <= (w_shn == '0);
            r_c     <= r_sh[0];
            r_n     <= w_shn[WIDTH-1];
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blue_exec_unit.sv
// Directed self-checking bench for blue_exec_unit.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_blue_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] ra;
  logic [15:0] rb;
  logic [3:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        flag_z;
  logic        flag_c;
  logic        flag_n;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  blue_exec_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ra(ra), .rb(rb), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] zcn);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".a"}, {16'd0, out_a}, {16'd0, a});
    chk({tag, ".b"}, {16'd0, out_b}, {16'd0, b});
    chk({tag, ".zcn"}, {29'd0, flag_z, flag_c, flag_n}, {29'd0, zcn});
  endtask

  task automatic drive(input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] s);
    in_valid = 1'b1;
    op = o;
    ra = a;
    rb = b;
    shamt = s;
  endtask

  initial begin
    int n;
    int lo;
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    op = 3'b000;
    ra = '0;
    rb = '0;
    shamt = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.a", {16'd0, out_a}, 32'd0);
    chk("rst.b", {16'd0, out_b}, 32'd0);
    chk("rst.zcn", {29'd0, flag_z, flag_c, flag_n}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

    // ADD with carry-out, held while out_ready low
    drive(3'b100, 16'hFFFF, 16'h0001, 4'd0);
    tick();
    in_valid = 1'b0;
    chk_res("add_carry", 16'h0000, 16'h0001, 3'b110);
    chk("add.in_ready_hold", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("add.in_ready_rel", {31'd0, in_ready}, 32'd1);
    tick();
    chk("add.idle_valid", {31'd0, out_valid}, 32'd0);

    // SUB with borrow
    drive(3'b101, 16'h0003, 16'h0005, 4'd0);
    tick();
    in_valid = 1'b0;
    chk_res("sub_borrow", 16'hFFFE, 16'h0005, 3'b011);
    tick();
    chk("sub.hold_a", {16'd0, out_a}, 32'h0000FFFE);

    // SHR 8001 >> 4: four SHIFT cycles, result in fifth cycle
    drive(3'b001, 16'h8001, 16'h7777, 4'd4);
    tick();
    in_valid = 1'b0;
    ra = 16'h1111;
    rb = 16'h2222;
    shamt = 4'd9;
    n = 1;
    lo = 0;
    while (!out_valid && n < 20) begin
      if (!in_ready) lo++;
      tick();
      n++;
    end
    chk("shr4.latency", n, 32'd5);
    chk("shr4.in_ready_low", lo, 32'd4);
    chk_res("shr4", 16'h0800, 16'h7777, 3'b000);
    tick();

    // SHR 0001 >> 1 shifts out the only set bit
    drive(3'b001, 16'h0001, 16'h0000, 4'd1);
    tick();
    in_valid = 1'b0;
    chk("shr1.busy", {31'd0, out_valid}, 32'd0);
    tick();
    chk_res("shr1", 16'h0000, 16'h0000, 3'b110);
    tick();

    // SHR by zero completes in one cycle with no carry
    drive(3'b001, 16'h80F0, 16'h0101, 4'd0);
    tick();
    in_valid = 1'b0;
    chk_res("shr0", 16'h80F0, 16'h0101, 3'b001);
    tick();

    // EXCH with downstream stalled for three cycles
    out_ready = 1'b0;
    drive(3'b011, 16'h1234, 16'hABCD, 4'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_res("exch_stall", 16'hABCD, 16'h1234, 3'b001);
      chk("exch.in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("exch.in_ready_rel", {31'd0, in_ready}, 32'd1);
    tick();
    chk("exch.idle_valid", {31'd0, out_valid}, 32'd0);
    chk("exch.idle_a", {16'd0, out_a}, 32'h0000ABCD);

    // Back-to-back stream, one result per cycle
    drive(3'b100, 16'h0010, 16'h0020, 4'd0);
    tick();
    chk_res("b2b.add", 16'h0030, 16'h0020, 3'b000);
    drive(3'b000, 16'h00FF, 16'h0F0F, 4'd0);
    #1;
    chk("b2b.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_res("b2b.xor", 16'h0FF0, 16'h0F0F, 3'b000);
    drive(3'b010, 16'h5A5A, 16'h0F0F, 4'd0);
    tick();
    chk_res("b2b.mov", 16'h5A5A, 16'h5A5A, 3'b000);
    drive(3'b110, 16'h00F0, 16'h0F00, 4'd0);
    tick();
    chk_res("b2b.or", 16'h0FF0, 16'h0F00, 3'b000);
    drive(3'b111, 16'hF0F0, 16'hFF00, 4'd0);
    tick();
    chk_res("b2b.and", 16'hF000, 16'hFF00, 3'b001);
    drive(3'b101, 16'h0005, 16'h0005, 4'd0);
    tick();
    chk_res("b2b.sub0", 16'h0000, 16'h0005, 3'b100);
    in_valid = 1'b0;
    tick();
    chk("b2b.drain", {31'd0, out_valid}, 32'd0);

    // Reset during a long shift discards it
    drive(3'b001, 16'hFFFF, 16'h4321, 4'd15);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstshr.valid", {31'd0, out_valid}, 32'd0);
    chk("rstshr.a", {16'd0, out_a}, 32'd0);
    chk("rstshr.b", {16'd0, out_b}, 32'd0);
    chk("rstshr.zcn", {29'd0, flag_z, flag_c, flag_n}, 32'd0);
    chk("rstshr.in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("rstshr.no_emit", seen, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
